// File: rtl/riscv_m_pkg.sv
// Shared encodings for the RV32M iterative multiply/divide unit.
//   m_funct3_e     : funct3 encodings of the M-extension operations
//   muldiv_state_e : sequencer states of muldiv_seq_unit
//   FUNCT7_MULDIV  : funct7 value decode uses to route R-type ops here
package riscv_m_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } m_funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration, purely combinational.
//   is_div : 1 = restoring shift-subtract step, 0 = shift-add step
//   acc_i  : high accumulator (mul: upper product half, div: partial remainder)
//   lo_i   : low register (mul: lower product half / multiplier, div: dividend / quotient)
//   opnd_i : multiplicand (mul) or divisor (div) magnitude
//   acc_o, lo_o : register values after this step
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    // Mul: conditionally add multiplicand, then shift {sum, lo} right by one.
    sum     = acc_i + (lo_i[0] ? {1'b0, opnd_i} : '0);
    // Div: shift next dividend bit into the remainder, trial-subtract divisor.
    shifted = {acc_i, lo_i[WIDTH-1]};
    diff    = shifted - {2'b00, opnd_i};
    acc_o   = '0;
    lo_o    = '0;
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        acc_o = diff[WIDTH:0];
        lo_o  = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH:0];
        lo_o  = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {1'b0, sum[WIDTH:1]};
      lo_o  = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M multiply/divide unit, one radix-2 step per cycle.
//   clk, rst_n     : clock, async active-low reset
//   start, flush   : request (sampled in IDLE) and pipeline abort
//   funct3         : M-extension operation select
//   op_a, op_b     : rs1 / rs2 operands, sampled only on accept
//   busy           : high while an operation occupies the unit (CALC, DONE)
//   done           : one-cycle completion pulse, masked by flush
//   result         : final value, held until the next completion
module muldiv_seq_unit
  import riscv_m_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_e    state_q, state_d;
  m_funct3_e        funct3_q, funct3_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_lo;

  m_funct3_e        f_in;
  logic             a_sgn, b_sgn, is_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, fin;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (funct3_q[2]),
    .acc_i  (acc_q),
    .lo_i   (lo_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .lo_o   (step_lo)
  );

  // Operand decode and sign correction of the final step.
  always_comb begin
    f_in   = m_funct3_e'(funct3);
    a_sgn  = op_a[WIDTH-1] & ((f_in == MULH) || (f_in == MULHSU) ||
                              (f_in == DIV)  || (f_in == REM));
    b_sgn  = op_b[WIDTH-1] & ((f_in == MULH) || (f_in == DIV) || (f_in == REM));
    a_mag  = a_sgn ? (~op_a + WIDTH'(1)) : op_a;
    b_mag  = b_sgn ? (~op_b + WIDTH'(1)) : op_b;
    is_ovf = ((f_in == DIV) || (f_in == REM)) && (op_a == MIN_INT) && (op_b == '1);

    prod     = {step_acc[WIDTH-1:0], step_lo};
    prod_fix = neg_q ? (~prod + PW'(1)) : prod;
    quo_fix  = neg_q ? (~step_lo + WIDTH'(1)) : step_lo;
    rem_fix  = neg_q ? (~step_acc[WIDTH-1:0] + WIDTH'(1)) : step_acc[WIDTH-1:0];

    fin = '0;
    case (funct3_q)
      MUL:               fin = prod_fix[WIDTH-1:0];
      MULH, MULHSU,
      MULHU:             fin = prod_fix[PW-1:WIDTH];
      DIV, DIVU:         fin = quo_fix;
      default:           fin = rem_fix;
    endcase
  end

  // Sequencer next-state and register updates.
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    count_d  = count_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !flush) begin
          funct3_d = f_in;
          busy_d   = 1'b1;
          if (f_in[2] && (op_b == '0)) begin
            // Divide by zero: quotient all ones, remainder is the dividend.
            result_d = f_in[1] ? op_a : '1;
            state_d  = DONE;
            done_d   = 1'b1;
          end else if (is_ovf) begin
            result_d = f_in[1] ? '0 : MIN_INT;
            state_d  = DONE;
            done_d   = 1'b1;
          end else begin
            state_d = CALC;
            count_d = CW'(WIDTH - 1);
            acc_d   = '0;
            // Remainder takes the dividend's sign; all others the XOR.
            neg_d   = (f_in == REM) ? a_sgn : (a_sgn ^ b_sgn);
            lo_d    = f_in[2] ? a_mag : b_mag;
            opnd_d  = f_in[2] ? b_mag : a_mag;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = step_acc;
          lo_d  = step_lo;
          if (count_q == '0) begin
            result_d = fin;
            state_d  = DONE;
            done_d   = 1'b1;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      funct3_q <= MUL;
      count_q  <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // A flush landing in the DONE cycle must hide the pulse in that same cycle.
  assign busy   = busy_q;
  assign done   = done_q & ~flush;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed self-checking bench for muldiv_seq_unit (WIDTH=32).
module tb_muldiv_seq_unit;

  localparam int unsigned W = 32;
  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   funct3 = 3'b000;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done;
  logic [W-1:0] result;

  int checks   = 0;
  int failures = 0;

  muldiv_seq_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, then measure latency (cycles after accept edge) and busy length.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res,
                        input int exp_cyc, input bit start_in_done);
    int           cyc;
    int           busyc;
    bit           seen;
    logic [W-1:0] res;
    res = 'x;
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    funct3 = 3'($urandom);
    cyc = 1; busyc = 0; seen = 1'b0;
    while (!seen && cyc <= 60) begin
      if (busy) busyc++;
      if (done) begin
        seen = 1'b1;
        res  = result;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, "_done_seen"}, W'(seen), W'(1));
    check({tag, "_result"}, res, exp_res);
    check({tag, "_latency"}, W'(cyc), W'(exp_cyc));
    check({tag, "_busy_cycles"}, W'(busyc), W'(exp_cyc));
    if (start_in_done) begin
      @(negedge clk);
      funct3 = F_MUL; op_a = 32'd2; op_b = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    check({tag, "_done_pulse_end"}, W'(done), W'(0));
    check({tag, "_idle_after"}, W'(busy), W'(0));
  endtask

  initial begin
    int evts;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_result", result, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply family
    run_op("mul_7xm3", F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
    run_op("mulhu_ff", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("mulh_m1m1", F_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
    run_op("mulhsu_m1", F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);

    // Divide family; the last one also presents start in its DONE cycle
    run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b1);

    // Special cases complete one cycle after accept
    run_op("div_by0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0);
    run_op("rem_by0", F_REM, 32'd5, 32'd0, 32'd5, 1, 1'b0);

    // Flush at cycle 10 of a divide: no done, result keeps 5
    @(negedge clk);
    funct3 = F_DIV; op_a = 32'd1000; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("flush_busy_before", W'(busy), W'(1));
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_done_in_cycle", W'(done), W'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_after", W'(busy), W'(0));
    check("flush_result_kept", result, 32'd5);

    // Flush together with start in IDLE: nothing accepted
    @(negedge clk);
    funct3 = F_MUL; op_a = 32'd3; op_b = 32'd4; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", W'(busy), W'(0));
    evts = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) evts++;
    end
    check("flush_no_activity", W'(evts), W'(0));

    run_op("mul_3x4", F_MUL, 32'd3, 32'd4, 32'd12, 33, 1'b0);

    // Reset mid-operation, with a start presented while busy
    @(negedge clk);
    funct3 = F_MUL; op_a = 32'h1234; op_b = 32'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    funct3 = F_DIVU; op_a = 32'd9; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_ignored", W'(busy), W'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", W'(busy), W'(0));
    check("rst_mid_done", W'(done), W'(0));
    check("rst_mid_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    evts = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) evts++;
    end
    check("rst_no_service", W'(evts), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
